// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio sample reader: FSM state encoding,
// default bus widths and the silence level presented to the DAC path.
package audio_pkg;

  localparam int AUDIO_ADDR_W = 10;
  localparam int AUDIO_DATA_W = 8;

  localparam logic signed [AUDIO_DATA_W-1:0] SILENCE = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/audio_sample_reader.sv
// Plays a stored sound from a registered-output DPRAM, one sample per prescaler tick.
// Build option: define AUDIO_LOOP_EN to restart from address 0 instead of ending the sound.
module audio_sample_reader
  import audio_pkg::*;
#(
  parameter int ADDR_W = AUDIO_ADDR_W,
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     slowEnPulse,
  input  logic                     startPlay,
  input  logic                     stopPlay,
  input  logic        [ADDR_W-1:0] lastAddr,
  output logic        [ADDR_W-1:0] ramAddr,
  input  logic signed [DATA_W-1:0] ramData,
  output logic signed [DATA_W-1:0] sampleOut,
  output logic                     sampleValid,
  output logic                     busy,
  output logic                     done,
  output logic                     missedTick
);

  localparam logic signed [DATA_W-1:0] SILENCE_W = DATA_W'(SILENCE);

  state_t                     state_q, state_d;
  logic        [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic        [ADDR_W-1:0]   last_q, last_d;
  logic signed [DATA_W-1:0]   sample_q, sample_d;
  logic                       sample_valid_q, sample_valid_d;
  logic                       done_q, done_d;
  logic                       missed_q, missed_d;

  always_comb begin
    state_d        = state_q;
    ram_addr_d     = ram_addr_q;
    last_d         = last_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    missed_d       = missed_q;

    // Abort beats (re)start; a start pulse restarts even mid-sound.
    if (stopPlay && (state_q != ST_IDLE)) begin
      sample_d = SILENCE_W;
      state_d  = ST_IDLE;
    end else if (startPlay && !stopPlay) begin
      last_d     = lastAddr;
      ram_addr_d = '0;
      missed_d   = 1'b0;
      state_d    = ST_PRIME;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_PRIME: begin
          if (slowEnPulse) missed_d = 1'b1;
          state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (slowEnPulse) begin
            sample_d       = ramData;
            sample_valid_d = 1'b1;
            if (ram_addr_q != last_q) begin
              ram_addr_d = ram_addr_q + ADDR_W'(1);
              state_d    = ST_ADVANCE;
            end else begin
`ifdef AUDIO_LOOP_EN
              ram_addr_d = '0;
              state_d    = ST_ADVANCE;
`else
              state_d    = ST_DRAIN;
`endif
            end
          end
        end
        ST_ADVANCE: begin
          // The RAM is still fetching the new address, so a tick here is lost.
          if (slowEnPulse) missed_d = 1'b1;
          state_d = ST_PLAY;
        end
        ST_DRAIN: begin
          if (slowEnPulse) begin
            sample_d       = SILENCE_W;
            sample_valid_d = 1'b1;
            done_d         = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ram_addr_q     <= '0;
      last_q         <= '0;
      sample_q       <= SILENCE_W;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ram_addr_q     <= ram_addr_d;
      last_q         <= last_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      missed_q       <= missed_d;
    end
  end

  assign ramAddr     = ram_addr_q;
  assign sampleOut   = sample_q;
  assign sampleValid = sample_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign missedTick  = missed_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Bench for audio_sample_reader: directed scenarios plus randomized sounds checked
// against an expected-sample list built from the sound table.
module tb_audio_sample_reader;

  logic              clk = 1'b0;
  logic              reset;
  logic              slowEnPulse;
  logic              startPlay;
  logic              stopPlay;
  logic [9:0]        lastAddr;
  logic [9:0]        ramAddr;
  logic signed [7:0] ramData;
  logic signed [7:0] sampleOut;
  logic              sampleValid;
  logic              busy;
  logic              done;
  logic              missedTick;

  logic signed [7:0] mem [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  audio_sample_reader #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .slowEnPulse (slowEnPulse),
    .startPlay   (startPlay),
    .stopPlay    (stopPlay),
    .lastAddr    (lastAddr),
    .ramAddr     (ramAddr),
    .ramData     (ramData),
    .sampleOut   (sampleOut),
    .sampleValid (sampleValid),
    .busy        (busy),
    .done        (done),
    .missedTick  (missedTick)
  );

  always #10 clk = ~clk;

  // Registered-output sound table: data follows the address one cycle later.
  always @(posedge clk) ramData <= mem[ramAddr];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle of inputs after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic t, input logic s, input logic p);
    slowEnPulse = t;
    startPlay   = s;
    stopPlay    = p;
    @(negedge clk);
    slowEnPulse = 1'b0;
    startPlay   = 1'b0;
    stopPlay    = 1'b0;
  endtask

  task automatic fill_mem(input int last);
    for (int i = 0; i <= last; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Plays a whole single-shot sound and compares every sample with the table.
  task automatic run_sound(input string tag, input int last, input int period);
    int exp_q[$];
    int idx, last_v, max_addr, budget;
    bit done_seen;
    for (int i = 0; i <= last; i++) exp_q.push_back(int'(mem[i]));
    exp_q.push_back(0);
    idx = 0; last_v = 0; max_addr = 0; done_seen = 0;
    budget = (last + 4) * period + 10;
    lastAddr = 10'(last);
    cycle(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= budget && !done_seen; c++) begin
      cycle((c % period) == 0, 1'b0, 1'b0);
      if (int'(ramAddr) > max_addr) max_addr = int'(ramAddr);
      if (sampleValid) begin
        if (idx > 0) chk_eq({tag, "_gap"}, c - last_v, period);
        if (idx < exp_q.size()) chk_eq({tag, "_sample"}, int'(sampleOut), exp_q[idx]);
        last_v = c;
        idx++;
      end
      if (done) begin
        done_seen = 1;
        chk_eq({tag, "_count"}, idx, last + 2);
        chk_eq({tag, "_busy_at_done"}, int'(busy), 0);
        chk_eq({tag, "_out_at_done"}, int'(sampleOut), 0);
      end
    end
    chk_eq({tag, "_done_seen"}, int'(done_seen), 1);
    chk_eq({tag, "_max_addr"}, max_addr, last);
  endtask

  // Runs with periodic ticks until n sample pulses are seen; returns the cycle index.
  task automatic wait_valids(input int n, input int period, output int c_out, output int last_s);
    int cnt;
    cnt = 0; c_out = 0; last_s = 0;
    for (int c = 1; c <= n * period + 10 && cnt < n; c++) begin
      cycle((c % period) == 0, 1'b0, 1'b0);
      c_out = c;
      if (sampleValid) begin
        cnt++;
        last_s = int'(sampleOut);
      end
    end
    chk_eq("wait_valids_count", cnt, n);
  endtask

  initial begin
    int c_at, s_at, first_after;
    bit bad;
    reset = 1'b1; slowEnPulse = 1'b0; startPlay = 1'b0; stopPlay = 1'b0;
    lastAddr = '0; ramData = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk_eq("rst_addr", int'(ramAddr), 0);
    chk_eq("rst_out", int'(sampleOut), 0);
    chk_eq("rst_valid", int'(sampleValid), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_missed", int'(missedTick), 0);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);

`ifdef AUDIO_LOOP_EN
    mem[0] = 8'sd7; mem[1] = 8'sd9;
    lastAddr = 10'd1;
    cycle(1'b0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      wait_valids(1, 4, c_at, s_at);
      chk_eq("loop_sample", s_at, (k % 2 == 0) ? 7 : 9);
      if (done) bad = 1;
    end
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (done) bad = 1;
    end
    chk_eq("loop_no_done", int'(bad), 0);
    chk_eq("loop_busy", int'(busy), 1);
    cycle(1'b0, 1'b0, 1'b1);
    chk_eq("loop_stop_out", int'(sampleOut), 0);
    chk_eq("loop_stop_busy", int'(busy), 0);
`else
    // Basic four-sample sound.
    mem[0] = 8'sd10; mem[1] = 8'sd20; mem[2] = 8'sd30; mem[3] = 8'sd40;
    run_sound("t1", 3, 8);

    // Abort one cycle after the second sample.
    lastAddr = 10'd3;
    cycle(1'b0, 1'b1, 1'b0);
    wait_valids(2, 8, c_at, s_at);
    chk_eq("t2_second", s_at, 20);
    cycle(1'b0, 1'b0, 1'b1);
    chk_eq("t2_out", int'(sampleOut), 0);
    chk_eq("t2_busy", int'(busy), 0);
    bad = (done == 1'b1);
    for (int c = 1; c <= 40; c++) begin
      cycle((c % 8) == 0, 1'b0, 1'b0);
      if (done || sampleOut != 0 || busy) bad = 1;
    end
    chk_eq("t2_stays_idle", int'(bad), 0);

    // Restart during the third sample.
    cycle(1'b0, 1'b1, 1'b0);
    wait_valids(3, 8, c_at, s_at);
    chk_eq("t3_third", s_at, 30);
    cycle(1'b0, 1'b1, 1'b0);
    chk_eq("t3_addr", int'(ramAddr), 0);
    chk_eq("t3_hold", int'(sampleOut), 30);
    chk_eq("t3_busy", int'(busy), 1);
    first_after = -1;
    for (int c = c_at + 2; c <= c_at + 20 && first_after < 0; c++) begin
      cycle((c % 8) == 0, 1'b0, 1'b0);
      if (sampleValid) first_after = int'(sampleOut);
    end
    chk_eq("t3_restart_first", first_after, 10);
    cycle(1'b0, 1'b0, 1'b1);

    // One-sample sound with a negative value.
    mem[0] = -8'sd5;
    run_sound("t4", 0, 6);

    // Tick landing in the priming cycle.
    mem[0] = 8'sd1; mem[1] = 8'sd2; mem[2] = 8'sd3;
    lastAddr = 10'd2;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk_eq("t5_missed_set", int'(missedTick), 1);
    bad = 0;
    for (int c = 2; c <= 40 && busy; c++) begin
      cycle((c % 4) == 0, 1'b0, 1'b0);
      if (!missedTick) bad = 1;
    end
    chk_eq("t5_missed_sticky", int'(bad), 0);
    chk_eq("t5_missed_after_end", int'(missedTick), 1);
    cycle(1'b0, 1'b1, 1'b0);
    chk_eq("t5_missed_clear", int'(missedTick), 0);
    cycle(1'b0, 1'b1, 1'b1);
    chk_eq("t5_stop_wins", int'(busy), 0);

    for (int r = 0; r < 5; r++) begin
      int last, period;
      last = $urandom_range(0, 12);
      period = $urandom_range(2, 9);
      fill_mem(last);
      run_sound("rnd", last, period);
    end
`endif

    // Reset in the middle of playback.
    mem[0] = 8'sd11; mem[1] = 8'sd22; mem[2] = 8'sd33;
    lastAddr = 10'd2;
    cycle(1'b0, 1'b1, 1'b0);
    wait_valids(2, 5, c_at, s_at);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    chk_eq("mid_rst_addr", int'(ramAddr), 0);
    chk_eq("mid_rst_out", int'(sampleOut), 0);
    chk_eq("mid_rst_valid", int'(sampleValid), 0);
    chk_eq("mid_rst_busy", int'(busy), 0);
    chk_eq("mid_rst_done", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
